// File: rtl/mips_regfile_pkg.sv
// Shared types and defaults for the register file write scheduler.
// Holds width defaults, the register count and the write bundle struct.
package mips_regfile_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    // One register file write: destination index and value.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } rf_state_e;

endpackage

// File: rtl/regfile_aux_fifo.sv
// Two-entry in-order buffer for auxiliary register writes.
// Ports: clock/reset (sync, active-high); push_i/push_data_i enqueue;
//   pop_i retires the head; kill_i/kill_reg_i drop every entry for a
//   register; head_o/head_valid_o oldest entry; full_o; pending_o mask.
module regfile_aux_fifo
    import mips_regfile_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  rf_wr_t                 push_data_i,
    input  logic                   pop_i,
    input  logic                   kill_i,
    input  logic [RF_ADDR_W-1:0]   kill_reg_i,
    output rf_wr_t                 head_o,
    output logic                   head_valid_o,
    output logic                   full_o,
    output logic [RF_NUM_REGS-1:0] pending_o
);

    rf_wr_t     ent_q [2];
    rf_wr_t     ent_d [2];
    logic [1:0] vld_q;
    logic [1:0] vld_d;
    logic [1:0] keep;

    // Entries are kept compacted: slot 0 is always the oldest, and
    // slot 1 is only valid when slot 0 is.
    always_comb begin
        keep[0] = vld_q[0] && !pop_i
                  && !(kill_i && ent_q[0].rd == kill_reg_i);
        keep[1] = vld_q[1]
                  && !(kill_i && ent_q[1].rd == kill_reg_i);
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        vld_d    = 2'b00;
        unique case (keep)
            2'b11: begin
                vld_d = 2'b11;
            end
            2'b01: begin
                ent_d[1] = push_data_i;
                vld_d    = {push_i, 1'b1};
            end
            2'b10: begin
                ent_d[0] = ent_q[1];
                ent_d[1] = push_data_i;
                vld_d    = {push_i, 1'b1};
            end
            default: begin
                ent_d[0] = push_data_i;
                vld_d    = {1'b0, push_i};
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= 2'b00;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clock) begin
        ent_q[0] <= ent_d[0];
        ent_q[1] <= ent_d[1];
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < 2; i++) begin
            if (vld_q[i]) begin
                pending_o[ent_q[i].rd] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

    assign head_o       = ent_q[0];
    assign head_valid_o = vld_q[0];
    assign full_o       = vld_q[0] && vld_q[1];

endmodule

// File: rtl/regfile_write_sched.sv
// Shares the register file write port between writeback and an aux source.
// Ports: clock, reset (sync, active-high); wb_en/wb_reg/wb_data writeback;
//   aux_valid/aux_ready/aux_reg/aux_data aux handshake; rf_we/rf_waddr/
//   rf_wdata file write port; pending mask; init_busy stall request.
// Macro REGFILE_CLEAR_EN: zero registers 1..31 after reset before running.
module regfile_write_sched
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_reg,
    input  logic [DATA_W-1:0] aux_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       pending,
    output logic              init_busy
);

    logic              run;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef REGFILE_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RF_NUM_REGS - 1);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] clr_q;
    logic [ADDR_W-1:0] clr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            clr_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == ST_INIT) begin
            clr_d = clr_q + ADDR_W'(1);
            if (clr_q == CLR_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        run       = (state_q == ST_RUN) && !reset;
        clr_we    = (state_q == ST_INIT) && !reset;
        clr_addr  = clr_q;
        init_busy = reset || (state_q == ST_INIT);
    end
`else
    assign run       = !reset;
    assign clr_we    = 1'b0;
    assign clr_addr  = '0;
    assign init_busy = 1'b0;
`endif

    rf_wr_t head;
    rf_wr_t push_data;
    logic   head_vld;
    logic   full;
    logic   push;
    logic   pop;
    logic   kill;

    assign aux_ready = !full && run;
    // r0 writes complete the handshake but are dropped here.
    assign push      = aux_valid && aux_ready && (aux_reg != '0);
    assign push_data = '{rd: aux_reg, data: aux_data};
    assign pop       = run && !wb_en && head_vld;
    // A younger pipeline write supersedes buffered ones to the same reg.
    assign kill      = run && wb_en && (wb_reg != '0);

    regfile_aux_fifo u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .kill_i       (kill),
        .kill_reg_i   (wb_reg),
        .head_o       (head),
        .head_valid_o (head_vld),
        .full_o       (full),
        .pending_o    (pending)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (clr_we) begin
            rf_we    = 1'b1;
            rf_waddr = clr_addr;
        end else if (run && wb_en) begin
            rf_we    = (wb_reg != '0);
            rf_waddr = wb_reg;
            rf_wdata = wb_data;
        end else if (run && head_vld) begin
            rf_we    = 1'b1;
            rf_waddr = head.rd;
            rf_wdata = head.data;
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched with hand-computed expectations.
// Works with and without REGFILE_CLEAR_EN defined.
module tb_regfile_write_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_reg;
    logic [31:0] aux_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic        init_busy;

    int n_chk  = 0;
    int n_pass = 0;

    regfile_write_sched dut (
        .clock     (clock),
        .reset     (reset),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_reg   (aux_reg),
        .aux_data  (aux_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending),
        .init_busy (init_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic wr(input string tag, input logic [4:0] a,
                      input logic [31:0] d);
        chk({tag, "_we"}, 32'(rf_we), 32'd1);
        chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
        chk({tag, "_data"}, rf_wdata, d);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        aux_valid = 1'b0; aux_reg = '0; aux_data = '0;
        nxt();
        smp();
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_rdy", 32'(aux_ready), 32'd0);
        chk("rst_pend", pending, 32'd0);
`ifdef REGFILE_CLEAR_EN
        chk("rst_busy", 32'(init_busy), 32'd1);
`else
        chk("rst_busy", 32'(init_busy), 32'd0);
`endif
        nxt();
        reset = 1'b0;
`ifdef REGFILE_CLEAR_EN
        for (int i = 1; i < 32; i++) begin
            wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD;
            aux_valid = 1'b1; aux_reg = 5'd4;
            smp();
            chk("clr_busy", 32'(init_busy), 32'd1);
            chk("clr_rdy", 32'(aux_ready), 32'd0);
            wr("clr", 5'(i), 32'd0);
            nxt();
        end
        wb_en = 1'b0; aux_valid = 1'b0;
`endif
        smp();
        chk("run_busy", 32'(init_busy), 32'd0);
        chk("run_rdy", 32'(aux_ready), 32'd1);
        chk("run_pend", pending, 32'd0);

        // Same-cycle wb and aux.
        nxt();
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h1111;
        aux_valid = 1'b1; aux_reg = 5'd7; aux_data = 32'h2222;
        smp();
        wr("same_n", 5'd5, 32'h1111);
        chk("same_n_pend", pending, 32'd0);
        nxt();
        wb_en = 1'b0; aux_valid = 1'b0;
        smp();
        wr("same_n1", 5'd7, 32'h2222);
        chk("same_n1_pend", pending, 32'h80);
        nxt();
        smp();
        chk("same_n2_we", 32'(rf_we), 32'd0);
        chk("same_n2_pend", pending, 32'd0);

        // Buffer full under continuous wb.
        nxt();
        wb_en = 1'b1; wb_reg = 5'd10; wb_data = 32'h10;
        aux_valid = 1'b1; aux_reg = 5'd1; aux_data = 32'h101;
        smp();
        chk("full_rdy1", 32'(aux_ready), 32'd1);
        nxt();
        aux_reg = 5'd2; aux_data = 32'h202;
        smp();
        chk("full_rdy2", 32'(aux_ready), 32'd1);
        chk("full_pend1", pending, 32'h2);
        nxt();
        aux_reg = 5'd3; aux_data = 32'h303;
        smp();
        chk("full_rdy3", 32'(aux_ready), 32'd0);
        chk("full_pend2", pending, 32'h6);
        wr("full_wb", 5'd10, 32'h10);
        nxt();
        smp();
        chk("full_rdy4", 32'(aux_ready), 32'd0);
        nxt();
        wb_en = 1'b0;
        smp();
        wr("full_w1", 5'd1, 32'h101);
        chk("full_rdy5", 32'(aux_ready), 32'd0);
        nxt();
        smp();
        wr("full_w2", 5'd2, 32'h202);
        chk("full_rdy6", 32'(aux_ready), 32'd1);
        nxt();
        aux_valid = 1'b0;
        smp();
        wr("full_w3", 5'd3, 32'h303);
        chk("full_pend3", pending, 32'h8);
        nxt();
        smp();
        chk("full_idle", 32'(rf_we), 32'd0);
        chk("full_pend4", pending, 32'd0);

        // Two buffered writes to one register retire oldest first.
        nxt();
        wb_en = 1'b1; wb_reg = 5'd20; wb_data = 32'h20;
        aux_valid = 1'b1; aux_reg = 5'd6; aux_data = 32'h61;
        nxt();
        aux_data = 32'h62;
        nxt();
        wb_en = 1'b0; aux_valid = 1'b0;
        smp();
        wr("ord_1", 5'd6, 32'h61);
        chk("ord_pend1", pending, 32'h40);
        nxt();
        smp();
        wr("ord_2", 5'd6, 32'h62);
        chk("ord_pend2", pending, 32'h40);
        nxt();
        smp();
        chk("ord_pend3", pending, 32'd0);

        // WAW cancel.
        nxt();
        wb_en = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
        aux_valid = 1'b1; aux_reg = 5'd9; aux_data = 32'hAAAA;
        nxt();
        aux_valid = 1'b0; wb_reg = 5'd9; wb_data = 32'hBBBB;
        smp();
        wr("waw_wb", 5'd9, 32'hBBBB);
        chk("waw_pend1", pending, 32'h200);
        nxt();
        wb_en = 1'b0;
        smp();
        chk("waw_we", 32'(rf_we), 32'd0);
        chk("waw_pend2", pending, 32'd0);

        // Register 0.
        nxt();
        wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'h5;
        aux_valid = 1'b1; aux_reg = 5'd0; aux_data = 32'h6;
        smp();
        chk("r0_rdy", 32'(aux_ready), 32'd1);
        chk("r0_we1", 32'(rf_we), 32'd0);
        nxt();
        wb_en = 1'b0; aux_valid = 1'b0;
        smp();
        chk("r0_we2", 32'(rf_we), 32'd0);
        chk("r0_pend", pending, 32'd0);

        // Reset with two entries buffered.
        nxt();
        wb_en = 1'b1; wb_reg = 5'd11; wb_data = 32'hB;
        aux_valid = 1'b1; aux_reg = 5'd12; aux_data = 32'hC;
        nxt();
        aux_reg = 5'd13; aux_data = 32'hD;
        nxt();
        aux_valid = 1'b0;
        smp();
        chk("rr_pend1", pending, 32'h3000);
        nxt();
        wb_en = 1'b0; reset = 1'b1;
        smp();
        chk("rr_we1", 32'(rf_we), 32'd0);
        chk("rr_rdy", 32'(aux_ready), 32'd0);
        nxt();
        reset = 1'b0;
        smp();
        chk("rr_pend2", pending, 32'd0);
`ifdef REGFILE_CLEAR_EN
        wr("rr_clr", 5'd1, 32'd0);
        chk("rr_busy", 32'(init_busy), 32'd1);
`else
        chk("rr_we2", 32'(rf_we), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
